dbf_rx_ctrl: RTL and testbench
==============================

DBF_RX_CTRL -- requirements
Module: dbf_rx_ctrl

Interface
REQ-001 Parameter ADDR_WD, default 6, is the width of the delay-LUT address shared by all DBF channels.
REQ-002 Parameter TX_CYC, default 64, is the number of cycles tx_en is held high per line.
REQ-003 Parameter RX_CYC, default 4096, is the number of receive cycles start is held high per line.
REQ-004 Parameter ZONE_CYC, default 64, is the number of cycles per focal zone (dynamic-focus LUT step).
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 fire  in  1  single-cycle request to acquire one line.
REQ-008 abort  in  1  terminates any acquisition in progress.
REQ-009 cfg_wr  in  1  host LUT write strobe.
REQ-010 cfg_addr  in  ADDR_WD  host LUT write address.
REQ-011 tx_en  out  1  transmit window; channels treat samples as invalid while high.
REQ-012 start  out  1  receive window; channels output beamformed data while high.
REQ-013 dbf_lut_addr  out  ADDR_WD  coarse/fine delay LUT address to all channels.
REQ-014 dbf_lut_we  out  1  LUT write enable to all channels.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 line_done  out  1  single-cycle pulse at the end of a completed line.
REQ-017 cfg_err  out  1  single-cycle pulse when cfg_wr arrives outside IDLE.
REQ-018 line_cnt  out  16  count of completed lines, wraps 65535->0.

Function
REQ-019 All outputs are registered; every response appears one cycle after the causing input edge.
REQ-020 FSM states: IDLE, TX, RX, DONE.
REQ-021 IDLE: cfg_wr=1 drives dbf_lut_we=1 and dbf_lut_addr=cfg_addr next cycle; otherwise we=0 and addr=0.
REQ-022 IDLE with fire=1 and cfg_wr=0 goes to TX; fire together with cfg_wr performs the write and drops fire.
REQ-023 TX: tx_en=1 for exactly TX_CYC cycles, then RX; start=0 and dbf_lut_we=0 throughout.
REQ-024 RX: start=1 for exactly RX_CYC cycles, then DONE; tx_en=0 throughout.
REQ-025 RX: dbf_lut_addr=0 on the first RX cycle and increments after every ZONE_CYC cycles, saturating at 2^ADDR_WD-1.
REQ-026 DONE lasts one cycle: line_done=1, line_cnt+1, start=0, then IDLE.
REQ-027 fire outside IDLE is ignored with no side effect.
REQ-028 cfg_wr outside IDLE is ignored: no LUT write, cfg_err=1 for one cycle.
REQ-029 abort=1 in any state: IDLE next cycle, tx_en=start=dbf_lut_we=0, addr=0, no line_done, line_cnt unchanged; abort has priority over fire and cfg_wr.
REQ-030 Phase counter width is ceil(log2(max(TX_CYC,RX_CYC))); it reloads to 0 at each state entry.
REQ-031 Zone counter width is ceil(log2(ZONE_CYC)); it wraps at ZONE_CYC-1 and reloads to 0 on RX entry.

Reset
REQ-032 rst=1 at a clock edge forces IDLE and all outputs to 0, including line_cnt, and clears every counter.
REQ-033 rst mid-line (TX or RX) behaves as REQ-032; no line_done is emitted.

Structure
REQ-034 The shared package holds the FSM state encoding, the default values of ADDR_WD/TX_CYC/RX_CYC/ZONE_CYC, and the line_cnt width.
REQ-035 One sub-module, dbf_zone_step, holds the zone counter and the saturating LUT-address step logic; the FSM stays in dbf_rx_ctrl.

Verification (ADDR_WD=6, TX_CYC=4, RX_CYC=256, ZONE_CYC=64)
REQ-036 Nominal line: fire at cycle 0 -> tx_en cycles 1-4, start cycles 5-260, addr 0/1/2/3 starting at cycles 5/69/133/197, line_done at cycle 261, line_cnt=1.
REQ-037 Config: cfg_wr with cfg_addr=0x2A in IDLE -> dbf_lut_we=1 and addr=0x2A one cycle later; the same write during RX -> we stays 0 and cfg_err pulses.
REQ-038 Saturation: RX_CYC=8192 -> addr reaches 63 at RX cycle 4032 and holds 63 until DONE.
REQ-039 Abort at RX cycle 100 -> start=0 next cycle, busy=0, no line_done, line_cnt unchanged; the next fire runs a full line.
REQ-040 Collisions: fire together with cfg_wr in IDLE -> write occurs and state stays IDLE; fire during TX -> ignored; rst during TX -> all outputs 0 next cycle.
REQ-041 Wrap: 65536 completed lines -> line_cnt returns to 0.

Source files
------------

// File: rtl/dbf_rx_ctrl_pkg.sv
// Shared types and defaults for the DBF receive-line controller.
// FSM encoding, default geometry parameters and the line counter width.
package dbf_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TX   = 2'd1,
    ST_RX   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_ADDR_WD  = 6;
  localparam int DEF_TX_CYC   = 64;
  localparam int DEF_RX_CYC   = 4096;
  localparam int DEF_ZONE_CYC = 64;
  localparam int LINE_CNT_WD  = 16;

endpackage

// File: rtl/dbf_zone_step.sv
// Dynamic-focus zone counter: steps the delay-LUT address every ZONE_CYC RX cycles.
// addr_nxt is combinational (registered by the parent); no backpressure, clears whenever rx_run is low.
module dbf_zone_step
  import dbf_rx_ctrl_pkg::*;
#(
  parameter int ADDR_WD  = DEF_ADDR_WD,
  parameter int ZONE_CYC = DEF_ZONE_CYC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_run,
  output logic [ADDR_WD-1:0] addr_nxt
);

  localparam int ZN_WD = (ZONE_CYC > 1) ? $clog2(ZONE_CYC) : 1;
  localparam logic [ZN_WD-1:0]   ZONE_LAST = ZN_WD'(ZONE_CYC - 1);
  localparam logic [ADDR_WD-1:0] ADDR_MAX  = '1;

  logic [ZN_WD-1:0]   zone_cnt;
  logic [ZN_WD-1:0]   zone_cnt_nxt;
  logic [ADDR_WD-1:0] zone_addr;

  // Any cycle that is not a continuation of RX reloads both to zero.
  always_comb begin
    zone_cnt_nxt = '0;
    addr_nxt     = '0;
    if (rx_run) begin
      if (zone_cnt == ZONE_LAST) begin
        zone_cnt_nxt = '0;
        addr_nxt     = (zone_addr == ADDR_MAX) ? zone_addr : zone_addr + ADDR_WD'(1);
      end else begin
        zone_cnt_nxt = zone_cnt + ZN_WD'(1);
        addr_nxt     = zone_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zone_cnt  <= '0;
      zone_addr <= '0;
    end else begin
      zone_cnt  <= zone_cnt_nxt;
      zone_addr <= addr_nxt;
    end
  end

endmodule

// File: rtl/dbf_rx_ctrl.sv
// DBF line sequencer: IDLE -> TX window -> RX window with zone-stepped LUT address -> DONE.
// All outputs registered, one cycle after the causing edge; no backpressure, abort/rst return to IDLE at once.
module dbf_rx_ctrl
  import dbf_rx_ctrl_pkg::*;
#(
  parameter int ADDR_WD  = DEF_ADDR_WD,
  parameter int TX_CYC   = DEF_TX_CYC,
  parameter int RX_CYC   = DEF_RX_CYC,
  parameter int ZONE_CYC = DEF_ZONE_CYC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fire,
  input  logic                   abort,
  input  logic                   cfg_wr,
  input  logic [ADDR_WD-1:0]     cfg_addr,
  output logic                   tx_en,
  output logic                   start,
  output logic [ADDR_WD-1:0]     dbf_lut_addr,
  output logic                   dbf_lut_we,
  output logic                   busy,
  output logic                   line_done,
  output logic                   cfg_err,
  output logic [LINE_CNT_WD-1:0] line_cnt
);

  localparam int MAX_CYC = (TX_CYC > RX_CYC) ? TX_CYC : RX_CYC;
  localparam int PH_WD   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [PH_WD-1:0] TX_LAST = PH_WD'(TX_CYC - 1);
  localparam logic [PH_WD-1:0] RX_LAST = PH_WD'(RX_CYC - 1);

  state_t             state;
  state_t             state_nxt;
  logic [PH_WD-1:0]   phase;
  logic [PH_WD-1:0]   phase_nxt;
  logic               lut_wr;
  logic               err_nxt;
  logic               rx_run;
  logic [ADDR_WD-1:0] zone_addr_nxt;

  always_comb begin
    state_nxt = state;
    lut_wr    = 1'b0;
    err_nxt   = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_wr)    lut_wr    = 1'b1;
          else if (fire) state_nxt = ST_TX;
        end
        ST_TX: begin
          err_nxt = cfg_wr;
          if (phase == TX_LAST) state_nxt = ST_RX;
        end
        ST_RX: begin
          err_nxt = cfg_wr;
          if (phase == RX_LAST) state_nxt = ST_DONE;
        end
        ST_DONE: begin
          err_nxt   = cfg_wr;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Phase restarts on every state entry and sits at zero in IDLE.
  always_comb begin
    if ((state_nxt != state) || (state_nxt == ST_IDLE)) phase_nxt = '0;
    else                                                 phase_nxt = phase + PH_WD'(1);
  end

  assign rx_run = (state == ST_RX) && (state_nxt == ST_RX);

  dbf_zone_step #(
    .ADDR_WD  (ADDR_WD),
    .ZONE_CYC (ZONE_CYC)
  ) u_zone (
    .clk      (clk),
    .rst      (rst),
    .rx_run   (rx_run),
    .addr_nxt (zone_addr_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      phase        <= '0;
      tx_en        <= 1'b0;
      start        <= 1'b0;
      dbf_lut_addr <= '0;
      dbf_lut_we   <= 1'b0;
      busy         <= 1'b0;
      line_done    <= 1'b0;
      cfg_err      <= 1'b0;
      line_cnt     <= '0;
    end else begin
      state        <= state_nxt;
      phase        <= phase_nxt;
      tx_en        <= (state_nxt == ST_TX);
      start        <= (state_nxt == ST_RX);
      dbf_lut_we   <= lut_wr;
      dbf_lut_addr <= (state_nxt == ST_RX) ? zone_addr_nxt :
                      lut_wr               ? cfg_addr      : '0;
      busy         <= (state_nxt != ST_IDLE);
      line_done    <= (state_nxt == ST_DONE);
      cfg_err      <= err_nxt;
      if (state_nxt == ST_DONE) line_cnt <= line_cnt + LINE_CNT_WD'(1);
    end
  end

endmodule

// File: tb/tb_dbf_rx_ctrl.sv
// Directed bench for dbf_rx_ctrl: nominal, config, abort, collision, reset, saturation and wrap.
// Line-completion and LUT-write events are scoreboarded against queued expectations.
module tb_dbf_rx_ctrl;

  localparam int AW = 6;

  logic clk  = 1'b0;
  logic wclk = 1'b0;
  always #5 clk  = ~clk;
  always #1 wclk = ~wclk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic          rst, fire, abort, cfg_wr;
  logic [AW-1:0] cfg_addr;
  logic          tx_en, start, dbf_lut_we, busy, line_done, cfg_err;
  logic [AW-1:0] dbf_lut_addr;
  logic [15:0]   line_cnt;

  logic          s_fire;
  logic          s_tx_en, s_start, s_we, s_busy, s_done, s_err;
  logic [AW-1:0] s_addr;
  logic [15:0]   s_cnt;

  logic          w_rst, w_fire;
  logic          w_tx_en, w_start, w_we, w_busy, w_done, w_err;
  logic [AW-1:0] w_addr;
  logic [15:0]   w_cnt;
  int            w_lines = 0;

  dbf_rx_ctrl #(.ADDR_WD(AW), .TX_CYC(4), .RX_CYC(256), .ZONE_CYC(64)) dut (
    .clk(clk), .rst(rst), .fire(fire), .abort(abort), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .tx_en(tx_en), .start(start), .dbf_lut_addr(dbf_lut_addr), .dbf_lut_we(dbf_lut_we),
    .busy(busy), .line_done(line_done), .cfg_err(cfg_err), .line_cnt(line_cnt));

  dbf_rx_ctrl #(.ADDR_WD(AW), .TX_CYC(4), .RX_CYC(8192), .ZONE_CYC(64)) u_sat (
    .clk(clk), .rst(rst), .fire(s_fire), .abort(1'b0), .cfg_wr(1'b0), .cfg_addr('0),
    .tx_en(s_tx_en), .start(s_start), .dbf_lut_addr(s_addr), .dbf_lut_we(s_we),
    .busy(s_busy), .line_done(s_done), .cfg_err(s_err), .line_cnt(s_cnt));

  dbf_rx_ctrl #(.ADDR_WD(AW), .TX_CYC(1), .RX_CYC(1), .ZONE_CYC(1)) u_wrap (
    .clk(wclk), .rst(w_rst), .fire(w_fire), .abort(1'b0), .cfg_wr(1'b0), .cfg_addr('0),
    .tx_en(w_tx_en), .start(w_start), .dbf_lut_addr(w_addr), .dbf_lut_we(w_we),
    .busy(w_busy), .line_done(w_done), .cfg_err(w_err), .line_cnt(w_cnt));

  typedef struct { int cyc; logic [15:0] cnt; } done_ev_t;
  typedef struct { int cyc; logic [AW-1:0] addr; } wr_ev_t;
  done_ev_t done_q[$];
  wr_ev_t   wr_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push_done(input int c, input logic [15:0] n);
    done_ev_t e;
    e.cyc = c;
    e.cnt = n;
    done_q.push_back(e);
  endtask

  task automatic push_wr(input int c, input logic [AW-1:0] a);
    wr_ev_t e;
    e.cyc  = c;
    e.addr = a;
    wr_q.push_back(e);
  endtask

  always @(negedge clk) begin
    done_ev_t de;
    wr_ev_t   we;
    if (line_done === 1'b1) begin
      chk("done_expected", done_q.size() > 0, 1);
      if (done_q.size() > 0) begin
        de = done_q.pop_front();
        chk("done_cycle", cyc, de.cyc);
        chk("done_line_cnt", line_cnt, de.cnt);
      end
    end
    if (dbf_lut_we === 1'b1) begin
      chk("wr_expected", wr_q.size() > 0, 1);
      if (wr_q.size() > 0) begin
        we = wr_q.pop_front();
        chk("wr_cycle", cyc, we.cyc);
        chk("wr_addr", dbf_lut_addr, we.addr);
      end
    end
  end

  always @(negedge wclk) begin
    if (w_done === 1'b1) begin
      w_lines++;
      if (w_lines == 65535) chk("wrap_cnt_ffff", w_cnt, 16'hffff);
      if (w_lines == 65536) chk("wrap_cnt_zero", w_cnt, 16'h0000);
    end
  end

  initial begin
    int c0;
    int guard;
    rst = 1'b1; fire = 1'b0; abort = 1'b0; cfg_wr = 1'b0; cfg_addr = '0;
    s_fire = 1'b0; w_rst = 1'b1; w_fire = 1'b0;
    repeat (3) tick();
    chk("rst_tx_en", tx_en, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", dbf_lut_addr, 0);
    chk("rst_line_cnt", line_cnt, 0);
    rst = 1'b0; w_rst = 1'b0; w_fire = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Host write in IDLE
    cfg_wr = 1'b1; cfg_addr = 6'h2A; push_wr(cyc + 1, 6'h2A);
    tick();
    cfg_wr = 1'b0; cfg_addr = '0;
    chk("cfg_we_idle", dbf_lut_we, 1);
    chk("cfg_addr_idle", dbf_lut_addr, 6'h2A);
    chk("cfg_err_idle", cfg_err, 0);
    tick();
    chk("cfg_we_drop", dbf_lut_we, 0);
    chk("cfg_addr_drop", dbf_lut_addr, 0);

    // fire together with cfg_wr: write wins, no line starts
    fire = 1'b1; cfg_wr = 1'b1; cfg_addr = 6'h15; push_wr(cyc + 1, 6'h15);
    tick();
    fire = 1'b0; cfg_wr = 1'b0; cfg_addr = '0;
    chk("coll_busy", busy, 0);
    chk("coll_tx_en", tx_en, 0);
    tick();
    chk("coll_busy_hold", busy, 0);

    // abort outranks cfg_wr in IDLE
    abort = 1'b1; cfg_wr = 1'b1; cfg_addr = 6'h3F;
    tick();
    abort = 1'b0; cfg_wr = 1'b0; cfg_addr = '0;
    chk("abort_cfg_we", dbf_lut_we, 0);
    chk("abort_cfg_err", cfg_err, 0);

    // Nominal line, with a stray fire in TX and a cfg_wr in RX
    c0 = cyc; fire = 1'b1; push_done(c0 + 261, 16'd1);
    tick();
    fire = 1'b0;
    chk("nom_tx_first", tx_en, 1);
    chk("nom_start_in_tx", start, 0);
    chk("nom_busy", busy, 1);
    tick();
    fire = 1'b1;
    tick();
    fire = 1'b0;
    goto(c0 + 4);
    chk("nom_tx_last", tx_en, 1);
    goto(c0 + 5);
    chk("nom_tx_off", tx_en, 0);
    chk("nom_start_on", start, 1);
    chk("nom_addr0", dbf_lut_addr, 0);
    goto(c0 + 68);
    chk("nom_addr0_end", dbf_lut_addr, 0);
    goto(c0 + 69);
    chk("nom_addr1", dbf_lut_addr, 1);
    goto(c0 + 133);
    chk("nom_addr2", dbf_lut_addr, 2);
    goto(c0 + 197);
    chk("nom_addr3", dbf_lut_addr, 3);
    goto(c0 + 200);
    cfg_wr = 1'b1; cfg_addr = 6'h2A;
    tick();
    cfg_wr = 1'b0; cfg_addr = '0;
    chk("rx_cfg_err", cfg_err, 1);
    chk("rx_cfg_we", dbf_lut_we, 0);
    chk("rx_cfg_addr", dbf_lut_addr, 3);
    tick();
    chk("rx_cfg_err_pulse", cfg_err, 0);
    goto(c0 + 260);
    chk("nom_start_last", start, 1);
    chk("nom_addr_last", dbf_lut_addr, 3);
    goto(c0 + 261);
    chk("nom_done_start", start, 0);
    chk("nom_done_pulse", line_done, 1);
    chk("nom_line_cnt", line_cnt, 1);
    goto(c0 + 262);
    chk("nom_idle_busy", busy, 0);
    chk("nom_done_drop", line_done, 0);

    // Abort at RX cycle 100
    c0 = cyc; fire = 1'b1;
    tick();
    fire = 1'b0;
    goto(c0 + 5 + 100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_start", start, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", dbf_lut_addr, 0);
    goto(c0 + 280);
    chk("abort_line_cnt", line_cnt, 1);

    c0 = cyc; fire = 1'b1; push_done(c0 + 261, 16'd2);
    tick();
    fire = 1'b0;
    goto(c0 + 262);
    chk("post_abort_cnt", line_cnt, 2);

    // Reset mid-TX
    c0 = cyc; fire = 1'b1;
    tick();
    fire = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_tx_tx_en", tx_en, 0);
    chk("rst_tx_busy", busy, 0);
    chk("rst_tx_line_cnt", line_cnt, 0);
    goto(c0 + 300);
    chk("rst_tx_stays_idle", busy, 0);

    c0 = cyc; fire = 1'b1; push_done(c0 + 261, 16'd1);
    tick();
    fire = 1'b0;
    goto(c0 + 262);
    chk("post_rst_cnt", line_cnt, 1);

    // Address saturation with a long RX window
    c0 = cyc; s_fire = 1'b1;
    tick();
    s_fire = 1'b0;
    goto(c0 + 5 + 4031);
    chk("sat_addr62", s_addr, 62);
    goto(c0 + 5 + 4032);
    chk("sat_addr63", s_addr, 63);
    goto(c0 + 5 + 8191);
    chk("sat_addr_hold", s_addr, 63);
    chk("sat_start_last", s_start, 1);
    goto(c0 + 5 + 8192);
    chk("sat_start_off", s_start, 0);
    chk("sat_done", s_done, 1);
    chk("sat_line_cnt", s_cnt, 1);

    // Wrap instance runs back-to-back lines on its own clock
    guard = 0;
    while (w_lines < 65536 && guard < 400000) begin
      @(posedge wclk);
      guard++;
    end
    chk("wrap_reached", w_lines >= 65536, 1);
    w_fire = 1'b0;

    tick();
    chk("done_q_empty", done_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
